receptor_pulsos: RTL
====================

# receptor_pulsos

Event-capture block on the receiving side of the button-pulse path. It takes the multi-cycle pulse train from the button synchronizer and qualifies each pulse by minimum width. It counts accepted events in a saturating counter and exposes a read-and-clear interface that the RISC-V core polls through its peripheral bus. Each accepted pulse produces exactly one count, regardless of pulse length.

## Interface
- `MIN_WIDTH`, default 4: minimum consecutive high cycles for a pulse to be accepted; legal range 2..255.
- `CNT_W`, default 8: event counter width; legal range 1..16.

- `clk_i`, input, 1: system clock. All logic is on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `pulse_i`, input, 1: pulse from the synchronizer; already synchronous to `clk_i`.
- `rd_i`, input, 1: single-cycle read-and-clear strobe from the bus.
- `count_o`, output, CNT_W: live event count.
- `pending_o`, output, 1: high when `count_o != 0` or overflow is set.
- `data_o`, output, CNT_W+1: `{overflow, count}` captured by the last read.
- `valid_o`, output, 1: one-cycle qualifier for `data_o`.

## Operation
- Registers: `pulse_prev`, `state`, `wcnt` (8 bit), `count` (CNT_W bit), `ovf`, `data_o`, `valid_o`.
- `pulse_prev <= pulse_i` every cycle.
- A rising edge means `pulse_i == 1 && pulse_prev == 0`.
- FSM states: IDLE, MEASURE, WAIT_LOW.
  - **IDLE**: on a rising edge, set `wcnt <= 1` and go to MEASURE. Otherwise stay in IDLE.
  - **MEASURE**, `pulse_i == 0`: glitch. Go to IDLE with no event.
  - **MEASURE**, `pulse_i == 1` and `wcnt + 1 == MIN_WIDTH`: accept the event and go to WAIT_LOW.
  - **MEASURE**, `pulse_i == 1` otherwise: `wcnt <= wcnt + 1` and stay in MEASURE.
  - **WAIT_LOW**: stay while `pulse_i == 1`. Go to IDLE when `pulse_i == 0`.
- Accepting an event:
  - If `count` is below `2^CNT_W - 1`, increment it.
  - Otherwise hold `count` at max and set `ovf <= 1`. Overflow is sticky until read.
- Read (`rd_i == 1`):
  - `data_o <= {ovf, count}`, using the values before this edge.
  - `valid_o <= 1`.
  - `count <= 0` and `ovf <= 0`.
- Read and accept on the same edge:
  - `data_o` captures the pre-event values.
  - `count <= 1` and `ovf <= 0`. The event is never lost.
- `valid_o` is low on every cycle that does not follow a read. `data_o` holds its value between reads.
- `pending_o` and `count_o` are combinational from the registers.
- `rd_i` has no effect on the FSM.

## Timing
- Reset values:
  - `state = IDLE`, `wcnt = 0`, `count = 0`, `ovf = 0`.
  - `data_o = 0`, `valid_o = 0`, `pending_o = 0`.
  - `pulse_prev = 1`, so a level already high when reset is released is not an edge.
- Reset in mid-pulse aborts any measurement with no event. The next event needs a fresh low-to-high transition.
- Accept latency: `pulse_i` first sampled high at edge E0. `count_o` updates after edge E0 + (MIN_WIDTH − 1).
- A pulse held high exactly MIN_WIDTH cycles is accepted; MIN_WIDTH − 1 cycles is rejected.
- A pulse of any length above MIN_WIDTH counts once.
- Read latency: `data_o` and `valid_o` are valid in the cycle after `rd_i`. Back-to-back reads on consecutive cycles are legal; the second returns 0 unless an event arrived in between.
- Minimum event spacing: MIN_WIDTH high cycles + 1 low cycle.

## Configuration
- Macro: `RECEPTOR_PULSOS_WIDTH_CHECK_EN`.
- Defined: full width qualification as described above.
- Undefined:
  - MEASURE and `wcnt` are not built, and `MIN_WIDTH` is ignored.
  - A rising edge in IDLE accepts the event immediately and goes to WAIT_LOW. `count_o` updates after E0.
  - All other behaviour is unchanged.

## Test plan
- **Reset with `pulse_i` held high**: hold `pulse_i = 1` through reset release for 10 cycles. Require `count_o = 0` and `pending_o = 0`.
- **Single pulse**: one 5-cycle pulse with MIN_WIDTH = 4. Require `count_o` to go 0→1 after E0+3, then stay at 1 after the pulse falls. Then `rd_i` returns `data_o = 0x001`, `valid_o` high for one cycle, and `count_o = 0`.
- **Glitch rejection** (macro on): 3-cycle pulse then 1-cycle pulse. Require `count_o = 0`. With the macro off, the same stimulus gives `count_o = 2`.
- **Saturation**: CNT_W = 2, six valid pulses. Require `count_o = 3` and `pending_o = 1`. A read returns `data_o = 3'b111`, then `count_o = 0` and overflow cleared.
- **Simultaneous read and accept**: `count_o = 2`, assert `rd_i` on the accepting edge. Require `data_o = 0x002` and `count_o = 1` afterwards.
- **Reset mid-pulse**: assert `rst_i` at E0+2 of a long pulse. Require `count_o = 0` and no event until `pulse_i` goes low and rises again.

Source files
------------

// File: rtl/receptor_pulsos.sv
// Button-pulse receiver: width-qualified edge capture into a saturating event counter
// with read-and-clear. Macro RECEPTOR_PULSOS_WIDTH_CHECK_EN enables minimum-width qualification.
module receptor_pulsos #(
  parameter int unsigned MIN_WIDTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pulse_i,
  input  logic             rd_i,
  output logic [CNT_W-1:0] count_o,
  output logic             pending_o,
  output logic [CNT_W:0]   data_o,
  output logic             valid_o
);

  if (MIN_WIDTH < 2 || MIN_WIDTH > 255 || CNT_W < 1 || CNT_W > 16) begin : g_param_check
    $error("receptor_pulsos: MIN_WIDTH or CNT_W out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
    MEASURE,
`endif
    WAIT_LOW
  } state_t;

  state_t           state_q, state_d;
  logic             pulse_prev;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             rise;
  logic             accept;
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
  logic [7:0]       wcnt_q, wcnt_d;
`endif

  assign rise = pulse_i & ~pulse_prev;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
          wcnt_d  = 8'd1;
          state_d = MEASURE;
`else
          accept  = 1'b1;
          state_d = WAIT_LOW;
`endif
        end
      end
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
      MEASURE: begin
        if (!pulse_i) begin
          state_d = IDLE;
        end else if (({1'b0, wcnt_q} + 9'd1) == 9'(MIN_WIDTH)) begin
          accept  = 1'b1;
          state_d = WAIT_LOW;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
        end
      end
`endif
      WAIT_LOW: begin
        if (!pulse_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A read clears the counter, but an event accepted on the same edge still counts as one.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (rd_i) begin
      count_d = accept ? CNT_W'(1) : '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (count_q != '1) count_d = count_q + CNT_W'(1);
      else               ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pulse_prev <= 1'b1;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
      wcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pulse_prev <= pulse_i;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_o    <= rd_i;
      if (rd_i) data_o <= {ovf_q, count_q};
`ifdef RECEPTOR_PULSOS_WIDTH_CHECK_EN
      wcnt_q     <= wcnt_d;
`endif
    end
  end

  assign count_o   = count_q;
  assign pending_o = (count_q != '0) | ovf_q;

endmodule
